// File: rtl/decode_stage_pkg.sv
// Shared RV32I opcode constants, decoded-bundle field widths and control-flag layout
// used by the decode queue and its combinational decoder.
package decode_stage_pkg;

  localparam int INSTR_W  = 32;
  localparam int REG_W    = 5;
  localparam int FUNCT3_W = 3;
  localparam int CTRL_W   = 8;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_e;

  typedef struct packed {
    logic mux2;
    logic mux3;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic reg_write;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational RV32I decode: register fields, format-assembled immediate
// sign-extended to XLEN, and ALU-source / class control flags.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0]  instr_i,
  output logic [REG_W-1:0]    rd_o,
  output logic [REG_W-1:0]    rs1_o,
  output logic [REG_W-1:0]    rs2_o,
  output logic [FUNCT3_W-1:0] funct3_o,
  output logic                opleft_o,
  output logic [XLEN-1:0]     imm_o,
  output logic [CTRL_W-1:0]   ctrl_o
);

  function automatic logic signed [31:0] imm32(input logic [31:0] w, input imm_fmt_e fmt);
    case (fmt)
      FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   return {w[31:12], 12'b0};
      FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return {{20{w[31]}}, w[31:20]};
    endcase
  endfunction

  ctrl_t    ctrl;
  imm_fmt_e fmt;
  logic signed [31:0] imm_s;

  assign rd_o     = instr_i[11:7];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign funct3_o = instr_i[14:12];
  assign opleft_o = instr_i[30];

  // Address-forming classes use rs1+imm; JAL/AUIPC use PC+imm; branches compare rs1/rs2.
  always_comb begin
    ctrl = '0;
    fmt  = FMT_I;
    case (instr_i[6:0])
      OPC_OP_IMM: begin ctrl.mux2 = 1'b1; ctrl.mux3 = 1'b1; ctrl.reg_write = 1'b1; end
      OPC_OP:     begin ctrl.mux2 = 1'b1; ctrl.reg_write = 1'b1; end
      OPC_LUI:    begin ctrl.mux2 = 1'b1; ctrl.mux3 = 1'b1; ctrl.reg_write = 1'b1; fmt = FMT_U; end
      OPC_AUIPC:  begin ctrl.mux3 = 1'b1; ctrl.reg_write = 1'b1; fmt = FMT_U; end
      OPC_JAL:    begin ctrl.mux3 = 1'b1; ctrl.jump = 1'b1; ctrl.reg_write = 1'b1; fmt = FMT_J; end
      OPC_JALR:   begin
        ctrl.mux2 = 1'b1; ctrl.mux3 = 1'b1; ctrl.jump = 1'b1; ctrl.reg_write = 1'b1;
      end
      OPC_BRANCH: begin ctrl.mux2 = 1'b1; ctrl.branch = 1'b1; fmt = FMT_B; end
      OPC_LOAD:   begin ctrl.mux2 = 1'b1; ctrl.mux3 = 1'b1; ctrl.load = 1'b1; ctrl.reg_write = 1'b1; end
      OPC_STORE:  begin ctrl.mux2 = 1'b1; ctrl.mux3 = 1'b1; ctrl.store = 1'b1; fmt = FMT_S; end
      OPC_MISC_MEM: ;
      default:    ctrl.illegal = 1'b1;
    endcase
  end

  assign imm_s  = imm32(instr_i, fmt);
  assign imm_o  = XLEN'(imm_s);
  assign ctrl_o = ctrl;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: QDEPTH-entry instruction queue feeding a registered decoded bundle
// with valid/ready handshakes on both sides and a priority flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    rs1,
  output logic [REG_W-1:0]    rs2,
  output logic [FUNCT3_W-1:0] opCode,
  output logic                opleft,
  output logic [XLEN-1:0]     imm,
  output logic                mux2,
  output logic                mux3,
  output logic                load,
  output logic                store,
  output logic                branch,
  output logic                jump,
  output logic                reg_write,
  output logic                illegal
);

  localparam int AW    = $clog2(QDEPTH);
  localparam int CNT_W = AW + 1;

  logic [INSTR_W-1:0] instr_mem_q [QDEPTH];
  logic [XLEN-1:0]    pc_mem_q    [QDEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               enq, deq;

  logic                out_valid_q;
  logic [XLEN-1:0]     out_pc_q, imm_q;
  logic [REG_W-1:0]    rd_q, rs1_q, rs2_q;
  logic [FUNCT3_W-1:0] funct3_q;
  logic                opleft_q;
  ctrl_t               ctrl_q;

  logic [REG_W-1:0]    dec_rd, dec_rs1, dec_rs2;
  logic [FUNCT3_W-1:0] dec_funct3;
  logic                dec_opleft;
  logic [XLEN-1:0]     dec_imm;
  logic [CTRL_W-1:0]   dec_ctrl;

  assign in_ready = (count_q != CNT_W'(QDEPTH));
  assign enq      = in_valid && in_ready;
  assign deq      = (count_q != '0) && (!out_valid_q || out_ready);

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage carries no reset; only occupancy and pointers define its contents.
  always_ff @(posedge clk) begin
    if (enq && !flush && !rst) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .instr_i  (instr_mem_q[rd_ptr_q]),
    .rd_o     (dec_rd),
    .rs1_o    (dec_rs1),
    .rs2_o    (dec_rs2),
    .funct3_o (dec_funct3),
    .opleft_o (dec_opleft),
    .imm_o    (dec_imm),
    .ctrl_o   (dec_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      opleft_q    <= 1'b0;
      ctrl_q      <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (enq) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        out_valid_q <= 1'b1;
        out_pc_q    <= pc_mem_q[rd_ptr_q];
        imm_q       <= dec_imm;
        rd_q        <= dec_rd;
        rs1_q       <= dec_rs1;
        rs2_q       <= dec_rs2;
        funct3_q    <= dec_funct3;
        opleft_q    <= dec_opleft;
        ctrl_q      <= ctrl_t'(dec_ctrl);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign imm       = imm_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign opCode    = funct3_q;
  assign opleft    = opleft_q;
  assign mux2      = ctrl_q.mux2;
  assign mux3      = ctrl_q.mux3;
  assign load      = ctrl_q.load;
  assign store     = ctrl_q.store;
  assign branch    = ctrl_q.branch;
  assign jump      = ctrl_q.jump;
  assign reg_write = ctrl_q.reg_write;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: XLEN=32 and XLEN=64 instances driven in lockstep and
// compared each cycle against a queue-based reference of the decode stage.
module tb_decode_stage;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        rdy32, ov32, ol32, m2_32, m3_32, ld32, st32, br32, jp32, rw32, il32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  op32;

  logic        rdy64, ov64, ol64, m2_64, m3_64, ld64, st64, br64, jp64, rw64, il64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  op64;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .QDEPTH(QD)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_pc(pc32), .rd(rd32), .rs1(rs1_32), .rs2(rs2_32), .opCode(op32), .opleft(ol32),
    .imm(imm32), .mux2(m2_32), .mux3(m3_32), .load(ld32), .store(st32), .branch(br32),
    .jump(jp32), .reg_write(rw32), .illegal(il32));

  decode_stage #(.XLEN(64), .QDEPTH(QD)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
    .out_pc(pc64), .rd(rd64), .rs1(rs1_64), .rs2(rs2_64), .opCode(op64), .opleft(ol64),
    .imm(imm64), .mux2(m2_64), .mux3(m3_64), .load(ld64), .store(st64), .branch(br64),
    .jump(jp64), .reg_write(rw64), .illegal(il64));

  typedef struct { logic [31:0] w; logic [63:0] pc; } ent_t;
  typedef struct packed {
    logic [4:0] rd, rs1, rs2; logic [2:0] f3; logic ol; logic [63:0] imm;
    logic m2, m3, ld, st, br, jp, rw, il;
  } exp_t;

  ent_t mq[$];
  ent_t m_out;
  bit   m_ov;
  int   n_checks = 0, n_err = 0, acc_cnt = 0;
  logic [6:0] ops [12] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6f, 7'h67,
                           7'h63, 7'h03, 7'h23, 7'h0f, 7'h73, 7'h7f};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    longint iv;
    e = '0;
    e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.f3 = w[14:12]; e.ol = w[30];
    iv = sx(longint'(w[31:20]), 12);
    case (w[6:0])
      7'h13: begin e.m2 = 1; e.m3 = 1; e.rw = 1; end
      7'h33: begin e.m2 = 1; e.rw = 1; end
      7'h37: begin e.m2 = 1; e.m3 = 1; e.rw = 1; iv = sx(longint'(w[31:12]) * 4096, 32); end
      7'h17: begin e.m3 = 1; e.rw = 1; iv = sx(longint'(w[31:12]) * 4096, 32); end
      7'h6f: begin
        e.m3 = 1; e.jp = 1; e.rw = 1;
        iv = sx(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      end
      7'h67: begin e.m2 = 1; e.m3 = 1; e.jp = 1; e.rw = 1; end
      7'h63: begin
        e.m2 = 1; e.br = 1;
        iv = sx(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      end
      7'h03: begin e.m2 = 1; e.m3 = 1; e.ld = 1; e.rw = 1; end
      7'h23: begin e.m2 = 1; e.m3 = 1; e.st = 1; iv = sx(longint'({w[31:25], w[11:7]}), 12); end
      7'h0f: ;
      default: e.il = 1;
    endcase
    e.imm = iv;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ov = 0;
  endtask

  task automatic model_edge();
    bit accept, take;
    if (rst || flush) begin
      model_clear();
    end else begin
      accept = in_valid && (mq.size() < QD);
      take   = (mq.size() > 0) && (!m_ov || out_ready);
      if (take) begin m_out = mq.pop_front(); m_ov = 1; end
      else if (out_ready) m_ov = 0;
      if (accept) begin mq.push_back('{in_instr, in_pc}); acc_cnt++; end
    end
  endtask

  task automatic check_out();
    exp_t e;
    chk("out_valid32", ov32, m_ov);
    chk("out_valid64", ov64, m_ov);
    if (m_ov) begin
      e = ref_decode(m_out.w);
      chk("out_pc32", pc32, m_out.pc[31:0]);
      chk("out_pc64", pc64, m_out.pc);
      chk("regs32", {rd32, rs1_32, rs2_32, op32, ol32}, {e.rd, e.rs1, e.rs2, e.f3, e.ol});
      chk("regs64", {rd64, rs1_64, rs2_64, op64, ol64}, {e.rd, e.rs1, e.rs2, e.f3, e.ol});
      chk("imm32", imm32, e.imm[31:0]);
      chk("imm64", imm64, e.imm);
      chk("flags32", {m2_32, m3_32, ld32, st32, br32, jp32, rw32, il32},
          {e.m2, e.m3, e.ld, e.st, e.br, e.jp, e.rw, e.il});
      chk("flags64", {m2_64, m3_64, ld64, st64, br64, jp64, rw64, il64},
          {e.m2, e.m3, e.ld, e.st, e.br, e.jp, e.rw, e.il});
    end
  endtask

  // Inputs are set by the caller at the negedge; one call advances one clock.
  task automatic cyc();
    chk("in_ready32", rdy32, mq.size() < QD);
    chk("in_ready64", rdy64, mq.size() < QD);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out();
  endtask

  task automatic chk_reset();
    chk("rst_valid", {ov32, ov64}, 2'b00);
    chk("rst_ready", {rdy32, rdy64}, 2'b11);
    chk("rst_pc", pc64 | {32'b0, pc32}, 64'd0);
    chk("rst_imm", imm64 | {32'b0, imm32}, 64'd0);
    chk("rst_regs", {rd32, rs1_32, rs2_32, op32, ol32, rd64, rs1_64, rs2_64, op64, ol64}, 0);
    chk("rst_flags", {m2_32, m3_32, ld32, st32, br32, jp32, rw32, il32,
                      m2_64, m3_64, ld64, st64, br64, jp64, rw64, il64}, 0);
  endtask

  task automatic drain();
    in_valid = 0; flush = 0; rst = 0; out_ready = 1;
    repeat (QD + 3) cyc();
  endtask

  task automatic push_one(input logic [31:0] w);
    in_valid = 1; in_instr = w; in_pc = {$urandom(), $urandom()}; out_ready = 1;
    cyc();
    in_valid = 0;
    chk("lat_edge1", ov32, 1'b0);
    cyc();
    chk("lat_edge2", ov32, 1'b1);
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
    @(negedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_clear();
    chk_reset();
    rst = 0;

    push_one(32'hFFF10093);
    chk("addi_rd_rs1", {rd32, rs1_32}, {5'd1, 5'd2});
    chk("addi_imm32", imm32, 32'hFFFF_FFFF);
    chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_flags", {m3_32, rw32}, 2'b11);
    drain();

    push_one(32'hFE000EE3);
    chk("beq_imm", imm32, 32'hFFFF_FFFC);
    chk("beq_flags", {br32, rw32}, 2'b10);
    drain();

    push_one(32'h008000EF);
    chk("jal_imm", imm32, 32'd8);
    chk("jal_flags", {jp32, rd32}, {1'b1, 5'd1});
    drain();

    push_one(32'h123452B7);
    chk("lui_imm", imm64, 64'h0000_0000_1234_5000);
    chk("lui_rd", rd32, 5'd5);
    drain();

    push_one(32'h00000073);
    chk("ecall_flags", {il32, rw32}, 2'b10);
    drain();

    // Back-pressure: output register plus QD queue slots fill, then one release.
    out_ready = 0; acc_cnt = 0; in_valid = 1;
    repeat (6) begin in_instr = rand_instr(); in_pc = {$urandom(), $urandom()}; cyc(); end
    chk("full_accepted", acc_cnt, 5);
    chk("full_in_ready", rdy32, 1'b0);
    out_ready = 1; cyc();
    out_ready = 0;
    repeat (2) begin in_instr = rand_instr(); cyc(); end
    chk("release_accepted", acc_cnt, 6);
    drain();

    // Flush with three queued, output valid and a same-cycle input.
    out_ready = 0; in_valid = 1;
    repeat (4) begin in_instr = rand_instr(); in_pc = {$urandom(), $urandom()}; cyc(); end
    chk("pre_flush_valid", ov32, 1'b1);
    flush = 1; in_instr = rand_instr(); cyc();
    chk("flush_valid", ov32, 1'b0);
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (4) cyc();
    chk("flush_quiet", {ov32, ov64}, 2'b00);
    push_one(rand_instr());
    drain();

    // Reset mid-stream takes priority over flush and a same-cycle input.
    out_ready = 0; in_valid = 1;
    repeat (3) begin in_instr = rand_instr(); in_pc = {$urandom(), $urandom()}; cyc(); end
    rst = 1; flush = 1; cyc();
    chk_reset();
    rst = 0; flush = 0;
    push_one(rand_instr());
    drain();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = (i == 200);
      in_instr  = rand_instr();
      in_pc     = {$urandom(), $urandom()};
      cyc();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
